// File: rtl/gpio_periph_if.sv
// CPU bus port bundle for the GPIO peripheral: one command channel and one
// single-cycle read response channel.
interface gpio_periph_if;
    logic        mem_cmd_sel;
    logic        mem_cmd_valid;
    logic        mem_cmd_wr;
    logic [11:0] mem_cmd_addr;
    logic [31:0] mem_cmd_wdata;
    logic        mem_rsp_ready;
    logic [31:0] mem_rsp_rdata;

    modport master (
        output mem_cmd_sel, mem_cmd_valid, mem_cmd_wr, mem_cmd_addr, mem_cmd_wdata,
        input  mem_rsp_ready, mem_rsp_rdata
    );

    modport slave (
        input  mem_cmd_sel, mem_cmd_valid, mem_cmd_wr, mem_cmd_addr, mem_cmd_wdata,
        output mem_rsp_ready, mem_rsp_rdata
    );
endinterface

// File: rtl/gpio_periph.sv
// Memory-mapped GPIO peripheral: DOUT/OE registers with set/clear/toggle
// aliases, a 2-flop input synchronizer, and a registered read response.
module gpio_periph #(
    parameter int NR_GPIOS = 8
) (
    input  logic                clk,
    input  logic                reset_,
    gpio_periph_if.slave        bus,
    output logic [NR_GPIOS-1:0] gpio_oe,
    output logic [NR_GPIOS-1:0] gpio_do,
    input  logic [NR_GPIOS-1:0] gpio_di
);

    localparam logic [9:0] WORD_DOUT = 10'h000;
    localparam logic [9:0] WORD_OE   = 10'h001;
    localparam logic [9:0] WORD_DIN  = 10'h002;
    localparam logic [9:0] WORD_SET  = 10'h003;
    localparam logic [9:0] WORD_CLR  = 10'h004;
    localparam logic [9:0] WORD_TGL  = 10'h005;

    logic [NR_GPIOS-1:0] dout_r;
    logic [NR_GPIOS-1:0] oe_r;
    logic [NR_GPIOS-1:0] sync1_r;
    logic [NR_GPIOS-1:0] sync2_r;
    logic                rsp_ready_r;
    logic [31:0]         rsp_rdata_r;

    logic                acc_s;
    logic                wr_s;
    logic                rd_s;
    logic [9:0]          word_s;
    logic [NR_GPIOS-1:0] wmask_s;
    logic [NR_GPIOS-1:0] dout_nxt_s;
    logic [NR_GPIOS-1:0] oe_nxt_s;
    logic [31:0]         rdata_nxt_s;
    logic                unused_s;

    // Byte-lane bits and wdata bits above the pin count carry no meaning here.
    assign unused_s = ^{bus.mem_cmd_addr[1:0], bus.mem_cmd_wdata};

    // Command qualification and word decode
    always_comb begin
        acc_s   = bus.mem_cmd_valid & bus.mem_cmd_sel;
        wr_s    = acc_s & bus.mem_cmd_wr;
        rd_s    = acc_s & ~bus.mem_cmd_wr;
        word_s  = bus.mem_cmd_addr[11:2];
        wmask_s = bus.mem_cmd_wdata[NR_GPIOS-1:0];
    end

    // Next value of the writable registers
    always_comb begin
        dout_nxt_s = dout_r;
        oe_nxt_s   = oe_r;
        if (wr_s) begin
            case (word_s)
                WORD_DOUT: dout_nxt_s = wmask_s;
                WORD_OE:   oe_nxt_s   = wmask_s;
                WORD_SET:  dout_nxt_s = dout_r | wmask_s;
                WORD_CLR:  dout_nxt_s = dout_r & ~wmask_s;
                WORD_TGL:  dout_nxt_s = dout_r ^ wmask_s;
                default: begin
                    dout_nxt_s = dout_r;
                    oe_nxt_s   = oe_r;
                end
            endcase
        end else begin
            dout_nxt_s = dout_r;
            oe_nxt_s   = oe_r;
        end
    end

    // Read data mux; write-only aliases and holes read as zero
    always_comb begin
        rdata_nxt_s = 32'h0000_0000;
        case (word_s)
            WORD_DOUT: rdata_nxt_s[NR_GPIOS-1:0] = dout_r;
            WORD_OE:   rdata_nxt_s[NR_GPIOS-1:0] = oe_r;
            WORD_DIN:  rdata_nxt_s[NR_GPIOS-1:0] = sync2_r;
            default:   rdata_nxt_s = 32'h0000_0000;
        endcase
    end

    // Register state, input synchronizer and read response
    always_ff @(posedge clk or negedge reset_) begin
        if (!reset_) begin
            dout_r      <= {NR_GPIOS{1'b0}};
            oe_r        <= {NR_GPIOS{1'b0}};
            sync1_r     <= {NR_GPIOS{1'b0}};
            sync2_r     <= {NR_GPIOS{1'b0}};
            rsp_ready_r <= 1'b0;
            rsp_rdata_r <= 32'h0000_0000;
        end else begin
            dout_r      <= dout_nxt_s;
            oe_r        <= oe_nxt_s;
            sync1_r     <= gpio_di;
            sync2_r     <= sync1_r;
            rsp_ready_r <= rd_s;
            if (rd_s) begin
                rsp_rdata_r <= rdata_nxt_s;
            end else begin
                rsp_rdata_r <= rsp_rdata_r;
            end
        end
    end

    assign gpio_do           = dout_r;
    assign gpio_oe           = oe_r;
    assign bus.mem_rsp_ready = rsp_ready_r;
    assign bus.mem_rsp_rdata = rsp_rdata_r;

endmodule

// File: tb/tb_gpio_periph.sv
// Randomized scoreboard bench for gpio_periph: stimulus pushes expected read
// responses, a negedge monitor pops and compares them along with pin outputs.
module tb_gpio_periph;
    localparam int          NR   = 8;
    localparam logic [31:0] MASK = 32'h0000_00FF;
    localparam int          HIST = 4096;

    typedef struct {
        int          due;
        logic [31:0] data;
    } exp_t;

    logic          clk = 1'b0;
    logic          reset_ = 1'b1;
    logic [NR-1:0] gpio_oe;
    logic [NR-1:0] gpio_do;
    logic [NR-1:0] gpio_di;

    gpio_periph_if bus();

    gpio_periph #(.NR_GPIOS(NR)) dut (
        .clk     (clk),
        .reset_  (reset_),
        .bus     (bus.slave),
        .gpio_oe (gpio_oe),
        .gpio_do (gpio_do),
        .gpio_di (gpio_di)
    );

    always #5 clk = ~clk;

    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    bit          mon_en = 1'b0;
    exp_t        sb_q[$];
    logic [NR-1:0] di_hist [0:HIST-1];
    logic [31:0] m_dout = 32'h0;
    logic [31:0] m_oe = 32'h0;
    logic [31:0] m_rdata = 32'h0;
    bit          pend_wr = 1'b0;
    logic [11:0] pend_addr;
    logic [31:0] pend_data;
    logic        exp_rdy;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Pin value seen at each clock edge; the sync flops hold zero while in reset.
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (cyc + 1 < HIST) di_hist[cyc+1] <= reset_ ? gpio_di : '0;
    end

    function automatic logic [31:0] model_read(input logic [11:0] addr);
        int w = int'(addr) / 4;
        case (w)
            0:       return m_dout;
            1:       return m_oe;
            2:       return (cyc >= 1) ? {24'h0, di_hist[cyc-1]} : 32'h0;
            default: return 32'h0;
        endcase
    endfunction

    function automatic void model_write(input logic [11:0] addr, input logic [31:0] wd);
        logic [31:0] v = wd & MASK;
        int w = int'(addr) / 4;
        case (w)
            0:       m_dout = v;
            1:       m_oe   = v;
            3:       m_dout = m_dout | v;
            4:       m_dout = m_dout & ~v;
            5:       m_dout = m_dout ^ v;
            default: ;
        endcase
    endfunction

    task automatic drive(input logic sel, input logic valid, input logic wr,
                         input logic [11:0] addr, input logic [31:0] wdata);
        exp_t e;
        bus.mem_cmd_sel   = sel;
        bus.mem_cmd_valid = valid;
        bus.mem_cmd_wr    = wr;
        bus.mem_cmd_addr  = addr;
        bus.mem_cmd_wdata = wdata;
        pend_wr = 1'b0;
        if (reset_ && sel && valid) begin
            if (wr) begin
                pend_wr   = 1'b1;
                pend_addr = addr;
                pend_data = wdata;
            end else begin
                e.due  = cyc + 1;
                e.data = model_read(addr);
                sb_q.push_back(e);
            end
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        if (pend_wr) model_write(pend_addr, pend_data);
        pend_wr = 1'b0;
        bus.mem_cmd_sel   = 1'b0;
        bus.mem_cmd_valid = 1'b0;
    endtask

    task automatic access(input logic sel, input logic valid, input logic wr,
                          input logic [11:0] addr, input logic [31:0] wdata);
        drive(sel, valid, wr, addr, wdata);
        step();
    endtask

    task automatic apply_reset(input int cycles);
        reset_ = 1'b0;
        sb_q.delete();
        m_dout  = 32'h0;
        m_oe    = 32'h0;
        m_rdata = 32'h0;
        pend_wr = 1'b0;
        #1;
        check("rst_ready", {31'h0, bus.mem_rsp_ready}, 32'h0);
        check("rst_rdata", bus.mem_rsp_rdata, 32'h0);
        check("rst_do", {24'h0, gpio_do}, 32'h0);
        check("rst_oe", {24'h0, gpio_oe}, 32'h0);
        for (int i = 0; i < cycles; i++) begin
            drive(1'($urandom), 1'($urandom), 1'($urandom), 12'($urandom), $urandom);
            step();
        end
        reset_ = 1'b1;
    endtask

    // Monitor: pops the scoreboard when a response is due and checks pins every cycle.
    always @(negedge clk) begin
        if (mon_en) begin
            exp_rdy = 1'b0;
            while (sb_q.size() > 0 && sb_q[0].due < cyc) void'(sb_q.pop_front());
            if (sb_q.size() > 0 && sb_q[0].due == cyc) begin
                exp_rdy = 1'b1;
                m_rdata = sb_q[0].data;
                void'(sb_q.pop_front());
            end
            check("rsp_ready", {31'h0, bus.mem_rsp_ready}, {31'h0, exp_rdy});
            check("rsp_rdata", bus.mem_rsp_rdata, m_rdata);
            check("gpio_do", {24'h0, gpio_do}, m_dout);
            check("gpio_oe", {24'h0, gpio_oe}, m_oe);
        end
    end

    initial begin
        logic [11:0] addr;
        bus.mem_cmd_sel   = 1'b0;
        bus.mem_cmd_valid = 1'b0;
        bus.mem_cmd_wr    = 1'b0;
        bus.mem_cmd_addr  = 12'h0;
        bus.mem_cmd_wdata = 32'h0;
        gpio_di = 8'h00;
        mon_en  = 1'b1;
        #1;
        apply_reset(4);
        repeat (2) step();

        // Write / readback, including upper wdata bits being dropped
        access(1'b1, 1'b1, 1'b1, 12'h000, 32'h0000_00A5);
        check("dout_a5", {24'h0, gpio_do}, 32'h0000_00A5);
        access(1'b1, 1'b1, 1'b1, 12'h004, 32'h0000_000F);
        check("oe_0f", {24'h0, gpio_oe}, 32'h0000_000F);
        access(1'b1, 1'b1, 1'b0, 12'h000, 32'h0);
        access(1'b1, 1'b1, 1'b0, 12'h004, 32'h0);
        access(1'b1, 1'b1, 1'b1, 12'h000, 32'hFFFF_FF3C);
        check("dout_3c", {24'h0, gpio_do}, 32'h0000_003C);
        access(1'b1, 1'b1, 1'b0, 12'h000, 32'h0);

        // Set / clear / toggle aliases, then reads of them
        access(1'b1, 1'b1, 1'b1, 12'h000, 32'h0000_00A5);
        access(1'b1, 1'b1, 1'b1, 12'h00C, 32'h0000_000A);
        check("set_af", {24'h0, gpio_do}, 32'h0000_00AF);
        access(1'b1, 1'b1, 1'b1, 12'h010, 32'h0000_0081);
        check("clr_2e", {24'h0, gpio_do}, 32'h0000_002E);
        access(1'b1, 1'b1, 1'b1, 12'h014, 32'h0000_00FF);
        check("tgl_d1", {24'h0, gpio_do}, 32'h0000_00D1);
        access(1'b1, 1'b1, 1'b0, 12'h00C, 32'h0);
        access(1'b1, 1'b1, 1'b0, 12'h010, 32'h0);
        access(1'b1, 1'b1, 1'b0, 12'h017, 32'h0);

        // Input synchronizer latency: new pin value visible on the third read
        gpio_di = 8'h5A;
        access(1'b1, 1'b1, 1'b0, 12'h008, 32'h0);
        access(1'b1, 1'b1, 1'b0, 12'h008, 32'h0);
        access(1'b1, 1'b1, 1'b0, 12'h008, 32'h0);

        // Unmapped offset, deselected and invalid commands
        access(1'b1, 1'b1, 1'b0, 12'h100, 32'h0);
        access(1'b1, 1'b1, 1'b1, 12'h100, 32'hFFFF_FFFF);
        access(1'b0, 1'b1, 1'b1, 12'h000, 32'h0000_0000);
        access(1'b1, 1'b0, 1'b1, 12'h004, 32'h0000_00FF);
        check("gated_do", {24'h0, gpio_do}, 32'h0000_00D1);
        access(1'b1, 1'b1, 1'b0, 12'h000, 32'h0);
        access(1'b1, 1'b1, 1'b0, 12'h008, 32'h0);

        // Reset asserted between a read command and its response edge
        drive(1'b1, 1'b1, 1'b0, 12'h000, 32'h0);
        #2;
        apply_reset(3);
        repeat (2) step();

        // Randomized traffic
        for (int n = 0; n < 400; n++) begin
            if ($urandom_range(0, 3) == 0) gpio_di = 8'($urandom);
            case ($urandom_range(0, 7))
                0, 1, 2, 3, 4, 5: addr = 12'($urandom_range(0, 5) * 4);
                6:                addr = 12'h100;
                default:          addr = 12'($urandom) & 12'hFFC;
            endcase
            addr = addr | 12'($urandom_range(0, 3));
            access($urandom_range(0, 5) != 0, $urandom_range(0, 5) != 0,
                   1'($urandom), addr, $urandom);
        end

        repeat (3) step();
        check("sb_drained", 32'(sb_q.size()), 32'h0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
